// File: rtl/branch_resolver.sv
// branch_resolver: execute-side branch resolution.
// In-flight prediction FIFO, mispredict flush/redirect, stats.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_valid,
  input  logic [31:0]      f_pc,
  input  logic             f_predict_valid,
  input  logic [31:0]      f_predict_addr,
  output logic             f_stall,
  input  logic             x_valid,
  input  logic             x_is_branch,
  input  logic             x_taken,
  input  logic [31:0]      x_target,
  output logic             x_predict_res,
  output logic             x_update_valid,
  output logic             x_mispredict,
  output logic [31:0]      x_redirect_pc,
  output logic             underflow_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } rec_t;

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;

  rec_t          head;
  logic          pop;
  logic          push;
  logic          under;
  logic          mis;
  logic          flush;
  logic [31:0]   cpc;

  assign f_stall = (occ == FULL);

  // Head-record resolution against the actual outcome.
  always_comb begin
    head  = mem[rd_ptr];
    pop   = x_valid && (occ != '0);
    under = x_valid && (occ == '0);
    push  = f_valid && (!f_stall || pop);
    cpc   = head.pc + 32'd4;
    mis   = 1'b0;
    unique case (1'b1)
      x_is_branch && x_taken: begin
        cpc = x_target;
        mis = !head.taken ||
              (head.target != x_target);
      end
      default: mis = head.taken;
    endcase
    flush = pop && mis;
  end

  // Record storage; a push in a flushing cycle is wrong-path.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= {f_pc, f_predict_valid, f_predict_addr};
  end

  // Pointers and occupancy; a flush empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Registered feedback, flush pulse and redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_predict_res  <= 1'b0;
      x_update_valid <= 1'b0;
      x_mispredict   <= 1'b0;
      x_redirect_pc  <= '0;
      underflow_err  <= 1'b0;
    end else begin
      x_update_valid <= pop && x_is_branch;
      x_predict_res  <= pop && x_is_branch && x_taken;
      x_mispredict   <= flush;
      if (flush) x_redirect_pc <= cpc;
      if (under) underflow_err <= 1'b1;
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (pop && x_is_branch && branch_cnt != CMAX)
        branch_cnt <= branch_cnt + 1'b1;
      if (flush && mispredict_cnt != CMAX)
        mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

endmodule
